// File: rtl/hps_reset_req_sequencer.sv
// ---------------------------------------------------------------------------
// hps_reset_req_sequencer
//
// Collects cold/warm/debug reset requests from fabric logic, arbitrates them
// (cold > warm > debug) and drives one fixed-width active-low pulse at a time
// toward the HPS reset-request inputs.  Each pulse is followed by a hold-off
// window before the next request is granted.
//
// Parameters
//   PULSE_CYCLES   : pulse width in clocks (1..65535)
//   HOLDOFF_CYCLES : dead time after each pulse in clocks (0..65535)
//
// Ports
//   clk_clk                            in   system clock
//   reset_reset_n                      in   asynchronous active-low reset
//   cold_req / warm_req / debug_req    in   rising edge = one request event
//   hps_0_f2h_*_reset_req_reset_n      out  active-low request pulses to HPS
//   busy                               out  sequencer not idle
//   last_kind                          out  last grant: 0 none,1 cold,2 warm,3 debug
//   issued_count                       out  granted pulses, modulo 256
// ---------------------------------------------------------------------------
module hps_reset_req_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1024
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       cold_req,
    input  logic       warm_req,
    input  logic       debug_req,
    output logic       hps_0_f2h_cold_reset_req_reset_n,
    output logic       hps_0_f2h_warm_reset_req_reset_n,
    output logic       hps_0_f2h_debug_reset_req_reset_n,
    output logic       busy,
    output logic [1:0] last_kind,
    output logic [7:0] issued_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Counter reload values; the hold-off load is only meaningful when enabled.
    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD  = (HOLDOFF_CYCLES == 0) ? 16'd0 : 16'(HOLDOFF_CYCLES - 1);
    localparam logic        HOLD_EN    = (HOLDOFF_CYCLES != 0);

    // Request vectors are ordered {cold, warm, debug}, i.e. bit 2 = highest priority.
    state_t      state_r;
    state_t      state_n_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_n_s;
    logic [2:0]  prev_r;
    logic [2:0]  pend_r;
    logic [2:0]  pend_n_s;
    logic [2:0]  out_r;        // active-low, same order as the request vector
    logic [2:0]  out_n_s;
    logic        busy_r;
    logic        busy_n_s;
    logic [1:0]  last_kind_r;
    logic [1:0]  last_kind_n_s;
    logic [7:0]  issued_r;
    logic [7:0]  issued_n_s;
    logic [2:0]  req_s;
    logic [2:0]  edge_s;
    logic [2:0]  clear_s;

    assign req_s  = {cold_req, warm_req, debug_req};
    assign edge_s = req_s & ~prev_r;

    // State, counter, edge history, pending bits and all registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            prev_r      <= 3'b000;
            pend_r      <= 3'b000;
            out_r       <= 3'b111;
            busy_r      <= 1'b0;
            last_kind_r <= 2'd0;
            issued_r    <= 8'd0;
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            prev_r      <= req_s;
            pend_r      <= pend_n_s;
            out_r       <= out_n_s;
            busy_r      <= busy_n_s;
            last_kind_r <= last_kind_n_s;
            issued_r    <= issued_n_s;
        end
    end

    // Next-state, arbitration and next-output logic.
    always_comb begin
        state_n_s     = state_r;
        cnt_n_s       = cnt_r;
        out_n_s       = out_r;
        last_kind_n_s = last_kind_r;
        issued_n_s    = issued_r;
        clear_s       = 3'b000;

        case (state_r)
            ST_IDLE: begin
                if (pend_r[2]) begin
                    // Cold reset supersedes everything already queued.
                    clear_s       = 3'b111;
                    out_n_s       = 3'b011;
                    last_kind_n_s = 2'd1;
                    cnt_n_s       = PULSE_LOAD;
                    issued_n_s    = issued_r + 8'd1;
                    state_n_s     = ST_ASSERT;
                end else if (pend_r[1]) begin
                    clear_s       = 3'b010;
                    out_n_s       = 3'b101;
                    last_kind_n_s = 2'd2;
                    cnt_n_s       = PULSE_LOAD;
                    issued_n_s    = issued_r + 8'd1;
                    state_n_s     = ST_ASSERT;
                end else if (pend_r[0]) begin
                    clear_s       = 3'b001;
                    out_n_s       = 3'b110;
                    last_kind_n_s = 2'd3;
                    cnt_n_s       = PULSE_LOAD;
                    issued_n_s    = issued_r + 8'd1;
                    state_n_s     = ST_ASSERT;
                end else begin
                    out_n_s   = 3'b111;
                    state_n_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (cnt_r == 16'd0) begin
                    out_n_s = 3'b111;
                    if (HOLD_EN) begin
                        cnt_n_s   = HOLD_LOAD;
                        state_n_s = ST_HOLDOFF;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    cnt_n_s = cnt_r - 16'd1;
                end
            end
            ST_HOLDOFF: begin
                out_n_s = 3'b111;
                if (cnt_r == 16'd0) begin
                    state_n_s = ST_IDLE;
                end else begin
                    cnt_n_s = cnt_r - 16'd1;
                end
            end
            default: begin
                out_n_s   = 3'b111;
                cnt_n_s   = 16'd0;
                state_n_s = ST_IDLE;
            end
        endcase

        // A fresh edge always survives a same-cycle grant of its kind.
        pend_n_s = (pend_r & ~clear_s) | edge_s;
        busy_n_s = (state_n_s != ST_IDLE);
    end

    assign hps_0_f2h_cold_reset_req_reset_n  = out_r[2];
    assign hps_0_f2h_warm_reset_req_reset_n  = out_r[1];
    assign hps_0_f2h_debug_reset_req_reset_n = out_r[0];
    assign busy                              = busy_r;
    assign last_kind                         = last_kind_r;
    assign issued_count                      = issued_r;

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Bench for hps_reset_req_sequencer: two instances (hold-off 8 and 0, pulse 4)
// share stimulus and are compared every cycle against a timestamp-based model.
module tb_hps_reset_req_sequencer;

    localparam int P = 4;
    localparam int HA = 8;
    localparam int HB = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cold = 1'b0;
    logic warm = 1'b0;
    logic debug = 1'b0;

    logic a_cold, a_warm, a_debug, a_busy;
    logic [1:0] a_lk;
    logic [7:0] a_ic;
    logic b_cold, b_warm, b_debug, b_busy;
    logic [1:0] b_lk;
    logic [7:0] b_ic;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hps_reset_req_sequencer #(.PULSE_CYCLES(P), .HOLDOFF_CYCLES(HA)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cold_req(cold), .warm_req(warm), .debug_req(debug),
        .hps_0_f2h_cold_reset_req_reset_n(a_cold),
        .hps_0_f2h_warm_reset_req_reset_n(a_warm),
        .hps_0_f2h_debug_reset_req_reset_n(a_debug),
        .busy(a_busy), .last_kind(a_lk), .issued_count(a_ic));

    hps_reset_req_sequencer #(.PULSE_CYCLES(P), .HOLDOFF_CYCLES(HB)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cold_req(cold), .warm_req(warm), .debug_req(debug),
        .hps_0_f2h_cold_reset_req_reset_n(b_cold),
        .hps_0_f2h_warm_reset_req_reset_n(b_warm),
        .hps_0_f2h_debug_reset_req_reset_n(b_debug),
        .busy(b_busy), .last_kind(b_lk), .issued_count(b_ic));

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (timestamps, not states) ----------
    int        t = 0;
    int        hold[2] = '{HA, HB};
    bit  [2:0] m_prev;
    bit  [2:0] m_pend[2];
    int        m_g[2];
    int        m_free[2];
    int        m_kind[2];
    int        m_last[2];
    int        m_cnt[2];

    task automatic model_reset();
        m_prev = 3'b000;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 3'b000;
            m_g[i]    = -1000;
            m_free[i] = 0;
            m_kind[i] = 0;
            m_last[i] = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_step();
        bit [2:0] req;
        bit [2:0] e;
        req = {cold, warm, debug};
        e = req & ~m_prev;
        m_prev = req;
        t++;
        for (int i = 0; i < 2; i++) begin
            if (t >= m_free[i] && m_pend[i] != 3'b000) begin
                if (m_pend[i][2]) begin
                    m_kind[i] = 1;
                    m_pend[i] = 3'b000;
                end else if (m_pend[i][1]) begin
                    m_kind[i] = 2;
                    m_pend[i][1] = 1'b0;
                end else begin
                    m_kind[i] = 3;
                    m_pend[i][0] = 1'b0;
                end
                m_g[i]    = t;
                m_free[i] = t + P + hold[i] + 1;
                m_last[i] = m_kind[i];
                m_cnt[i]  = (m_cnt[i] + 1) % 256;
            end
            m_pend[i] = m_pend[i] | e;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------------------------
    task automatic compare_one(input int i, input logic c, input logic w, input logic d,
                               input logic b, input logic [1:0] lk, input logic [7:0] ic);
        int low;
        int bz;
        low = (t >= m_g[i] && t < m_g[i] + P) ? m_kind[i] : 0;
        bz  = (t >= m_g[i] && t < m_g[i] + P + hold[i]) ? 1 : 0;
        chk(i == 0 ? "A.cold" : "B.cold", int'(c), low == 1 ? 0 : 1);
        chk(i == 0 ? "A.warm" : "B.warm", int'(w), low == 2 ? 0 : 1);
        chk(i == 0 ? "A.debug" : "B.debug", int'(d), low == 3 ? 0 : 1);
        chk(i == 0 ? "A.busy" : "B.busy", int'(b), bz);
        chk(i == 0 ? "A.last_kind" : "B.last_kind", int'(lk), m_last[i]);
        chk(i == 0 ? "A.issued_count" : "B.issued_count", int'(ic), m_cnt[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_one(0, a_cold, a_warm, a_debug, a_busy, a_lk, a_ic);
            compare_one(1, b_cold, b_warm, b_debug, b_busy, b_lk, b_ic);
        end
    end

    // ---------------- stimulus + literal expectations --------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cold = 1'b0; warm = 1'b0; debug = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        // Reset values
        tick(3);
        chk("rst.cold", int'(a_cold), 1);
        chk("rst.warm", int'(a_warm), 1);
        chk("rst.debug", int'(a_debug), 1);
        chk("rst.busy", int'(a_busy), 0);
        chk("rst.last_kind", int'(a_lk), 0);
        chk("rst.issued", int'(a_ic), 0);
        rst_n = 1'b1;
        tick(2);

        // Single warm edge: low after k+1 through k+4, high after k+5, busy ends after k+13
        warm = 1'b1; tick(1); warm = 1'b0;
        tick(1);
        chk("warm1.low_first", int'(a_warm), 0);
        chk("warm1.cold_hi", int'(a_cold), 1);
        chk("warm1.kind", int'(a_lk), 2);
        chk("warm1.count", int'(a_ic), 1);
        tick(3);
        chk("warm1.low_last", int'(a_warm), 0);
        tick(1);
        chk("warm1.released", int'(a_warm), 1);
        tick(7);
        chk("warm1.busy_end", int'(a_busy), 1);
        tick(1);
        chk("warm1.idle", int'(a_busy), 0);

        // Warm + debug same cycle: debug grant 13 cycles after warm grant
        do_reset();
        warm = 1'b1; debug = 1'b1; tick(1); warm = 1'b0; debug = 1'b0;
        tick(1);
        chk("wd.warm_low", int'(a_warm), 0);
        tick(12);
        chk("wd.gap", int'(a_debug), 1);
        tick(1);
        chk("wd.debug_low", int'(a_debug), 0);
        tick(20);
        chk("wd.count", int'(a_ic), 2);
        chk("wd.kind", int'(a_lk), 3);

        // Warm + debug pending, cold edge during warm pulse: debug discarded
        do_reset();
        warm = 1'b1; debug = 1'b1; tick(1); warm = 1'b0; debug = 1'b0;
        tick(2);
        cold = 1'b1; tick(1); cold = 1'b0;
        tick(40);
        chk("cwd.count", int'(a_ic), 2);
        chk("cwd.kind", int'(a_lk), 1);

        // Held-high level gives one event
        do_reset();
        warm = 1'b1; tick(100); warm = 1'b0;
        tick(20);
        chk("held.count", int'(a_ic), 1);

        // Reset in 2nd cycle of cold pulse, with a debug pending
        do_reset();
        cold = 1'b1; tick(1); cold = 1'b0;
        tick(1);
        chk("rmid.cold_low", int'(a_cold), 0);
        debug = 1'b1; tick(1); debug = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rmid.async_hi", int'(a_cold), 1);
        chk("rmid.busy", int'(a_busy), 0);
        tick(1);
        rst_n = 1'b1;
        tick(30);
        chk("rmid.no_pulse", int'(a_ic), 0);
        chk("rmid.debug_hi", int'(a_debug), 1);

        // Zero hold-off instance: grants 5 cycles apart, 256 grants wrap to 0
        do_reset();
        for (int n = 0; n < 256; n++) begin
            warm = 1'b1; tick(1);
            chk("wrap.pre_hi", int'(b_warm), 1);
            warm = 1'b0; tick(1);
            chk("wrap.grant_low", int'(b_warm), 0);
            tick(3);
        end
        tick(10);
        chk("wrap.count", int'(b_ic), 0);
        chk("wrap.kind", int'(b_lk), 2);

        // Randomized traffic with occasional resets; model checks each cycle
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) cold  = ~cold;
            if ($urandom_range(0, 5) == 0)  warm  = ~warm;
            if ($urandom_range(0, 5) == 0)  debug = ~debug;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
